// File: rtl/count_game_pkg.sv
// count_game_pkg: shared state encoding and digit constants for the count game.
package count_game_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
endpackage

// File: rtl/btn_edge.sv
// btn_edge: two-flop synchronizer followed by a registered rising-edge pulse.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);
  logic s1, s2, s2_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {s1, s2, s2_d, pulse} <= '0;
    else {s1, s2, s2_d, pulse} <= {din, s1, s2, s2 & ~s2_d};
endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: start/stop game FSM with a divided digit counter feeding the display driver.
module count_ctrl
  import count_game_pkg::*;
#(
  parameter int DIV    = 5_000_000,
  parameter int TARGET = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               stop_btn,
  output logic [DIGIT_W-1:0] num,
  output logic               st,
  output logic               win,
  output logic               lose
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [DIGIT_W-1:0] TGT = DIGIT_W'(TARGET);
  state_t state, state_n;
  logic [CW-1:0] div_cnt, div_n;
  logic [DIGIT_W-1:0] num_n;
  logic win_n, lose_n, start_p, stop_p, tick;
  btn_edge u_start (.clk(clk), .rst(rst), .din(start_btn), .pulse(start_p));
  btn_edge u_stop  (.clk(clk), .rst(rst), .din(stop_btn),  .pulse(stop_p));
  assign tick = div_cnt == LAST;
  assign st = state != IDLE;
  // stop takes priority over a coinciding digit step, so the frozen digit is the one shown
  always_comb begin
    state_n = state;
    div_n = div_cnt;
    num_n = num;
    win_n = win;
    lose_n = lose;
    case (state)
      IDLE: if (start_p) begin
        state_n = RUN;
        num_n = '0;
        div_n = '0;
      end
      RUN: if (stop_p) begin
        state_n = HOLD;
        win_n = num == TGT;
        lose_n = num != TGT;
      end else begin
        div_n = tick ? '0 : div_cnt + 1'b1;
        num_n = !tick ? num : num == MAX_DIGIT ? '0 : num + 1'b1;
      end
      HOLD: if (start_p) begin
        state_n = RUN;
        num_n = '0;
        div_n = '0;
        win_n = 1'b0;
        lose_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      div_cnt <= '0;
      num <= '0;
      win <= 1'b0;
      lose <= 1'b0;
    end else begin
      state <= state_n;
      div_cnt <= div_n;
      num <= num_n;
      win <= win_n;
      lose <= lose_n;
    end
endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed + randomized stimulus checked against a cycle-count game model.
module tb_count_ctrl;
  localparam int DIV = 4;
  localparam int TARGET = 3;
  logic clk = 0, rst = 0, start_btn = 0, stop_btn = 0;
  logic [3:0] num;
  logic st, win, lose;
  int n_cmp = 0, n_bad = 0;
  int mode = 0, c = 0, fz = 0;
  bit mw = 0, ml = 0;
  bit [4:0] hs = 0, hp = 0;

  count_ctrl #(.DIV(DIV), .TARGET(TARGET)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn),
    .num(num), .st(st), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // expected digit: number of completed DIV-cycle periods since the game began, mod 10
  task automatic check_all();
    logic [3:0] en;
    en = mode == 0 ? 4'd0 : mode == 1 ? 4'((c / DIV) % 10) : 4'(fz);
    chk("num", num, en);
    chk("st", {3'b0, st}, {3'b0, mode != 0});
    chk("win", {3'b0, win}, {3'b0, mw});
    chk("lose", {3'b0, lose}, {3'b0, ml});
  endtask

  // one clock: model reacts to a button that rose 3 edges before this one
  task automatic step();
    bit sp, pp;
    @(posedge clk);
    if (!rst) begin
      mode = 0; c = 0; fz = 0; mw = 0; ml = 0; hs = 0; hp = 0;
    end else begin
      hs = {hs[3:0], start_btn};
      hp = {hp[3:0], stop_btn};
      sp = hs[3] & ~hs[4];
      pp = hp[3] & ~hp[4];
      case (mode)
        0: if (sp) begin mode = 1; c = 0; end
        1: if (pp) begin
          mode = 2; fz = (c / DIV) % 10; mw = fz == TARGET; ml = !mw;
        end else c++;
        default: if (sp) begin mode = 1; c = 0; mw = 0; ml = 0; end
      endcase
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input bit s, input bit p);
    start_btn = s;
    stop_btn = p;
    step();
    start_btn = 0;
    stop_btn = 0;
  endtask

  task automatic run_to(input int tc);
    for (int i = 0; i < 2000 && !(mode == 1 && c == tc); i++) step();
    if (!(mode == 1 && c == tc)) begin
      n_bad++;
      $error("FAIL run_to: got mode %0d c %0d expected RUN c %0d", mode, c, tc);
    end
  endtask

  initial begin
    for (int i = 0; i < 12; i++) begin
      start_btn = 1'($urandom);
      stop_btn = 1'($urandom);
      step();
    end
    start_btn = 0; stop_btn = 0;
    rst = 1;
    steps(10);
    press(1, 0);
    steps(50);
    run_to(49);
    press(0, 1);
    steps(100);
    chk("hold_num3", num, 4'd3);
    chk("hold_win", {3'b0, win}, 4'd1);
    press(0, 1);
    steps(8);
    press(0, 1);
    steps(8);
    chk("hold_num3_again", num, 4'd3);
    press(1, 0);
    run_to(18);
    press(0, 1);
    steps(6);
    chk("lose_num5", num, 4'd5);
    chk("lose5", {3'b0, lose}, 4'd1);
    press(1, 0);
    run_to(8);
    press(0, 1);
    steps(6);
    chk("step_vs_stop", num, 4'd2);
    chk("lose2", {3'b0, lose}, 4'd1);
    press(1, 1);
    steps(10);
    chk("both_in_hold_st", {3'b0, st}, 4'd1);
    chk("both_in_hold_win", {3'b0, win}, 4'd0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) start_btn = ~start_btn;
      if ($urandom_range(9) == 0) stop_btn = ~stop_btn;
      step();
    end
    start_btn = 0; stop_btn = 0;
    steps(6);
    press(0, 1);
    steps(6);
    press(1, 0);
    run_to(25);
    chk("pre_reset_num6", num, 4'd6);
    #2 rst = 0;
    #1;
    chk("async_num", num, 4'd0);
    chk("async_st", {3'b0, st}, 4'd0);
    chk("async_wl", {2'b0, win, lose}, 4'd0);
    @(negedge clk);
    steps(2);
    rst = 1;
    steps(5);
    press(1, 0);
    steps(30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
